// File: rtl/rbcla_feed_pkg.sv
// Shared widths, types and helpers for the rbcla_feed_stage operand feeder.
// Optional statistics are enabled with RBCLA_FEED_STATS_EN.
package rbcla_feed_pkg;

    localparam int unsigned OP_W_DEF  = 29;
    localparam int unsigned SUM_W_DEF = 30;
    localparam int unsigned STAT_W    = 16;

    typedef logic [OP_W_DEF-1:0]  op_t;
    typedef logic [SUM_W_DEF-1:0] sum_t;

    typedef enum logic {
        OP_EMPTY  = 1'b0,
        OP_LOADED = 1'b1
    } op_state_t;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/UBRCL_28_0_28_0.sv
// 29-bit unsigned ripple-block carry look-ahead adder (4-bit lookahead groups,
// group carries rippled); purely combinational, 30-bit sum with carry on top.
module UBRCL_28_0_28_0 (
    input  logic [28:0] x,
    input  logic [28:0] y,
    output logic [29:0] s
);

    localparam int unsigned W   = 29;
    localparam int unsigned BLK = 4;

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] sv;
    logic         bcin;
    logic         gg;
    logic         pp;

    assign g = x & y;
    assign p = x ^ y;

    // gg/pp are the group generate/propagate from the group base up to bit i-1.
    always_comb begin
        sv   = '0;
        bcin = 1'b0;
        gg   = 1'b0;
        pp   = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            if ((i % BLK) == 0) begin
                bcin = gg | (pp & bcin);
                gg   = 1'b0;
                pp   = 1'b1;
            end
            sv[i] = p[i] ^ (gg | (pp & bcin));
            gg    = g[i] | (p[i] & gg);
            pp    = pp & p[i];
        end
    end

    assign s = {gg | (pp & bcin), sv};

endmodule

// File: rtl/rbcla_feed_fifo.sv
// Result FIFO: circular buffer with wrapping pointers, occupancy count and
// pass-through push when full and popped in the same cycle.
module rbcla_feed_fifo
    import rbcla_feed_pkg::*;
#(
    parameter int unsigned W     = SUM_W_DEF,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   cnt,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/rbcla_feed_stage.sv
// Operand register and result buffer around the combinational UBRCL_28_0_28_0
// adder. Optional counters/hold flag when RBCLA_FEED_STATS_EN is defined.
module rbcla_feed_stage
    import rbcla_feed_pkg::*;
#(
    parameter int unsigned OP_W       = OP_W_DEF,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_x,
    input  logic [OP_W-1:0]   in_y,
    output logic [OP_W-1:0]   add_x_o,
    output logic [OP_W-1:0]   add_y_o,
    input  logic [OP_W:0]     add_s_i,
`ifdef RBCLA_FEED_STATS_EN
    output logic [STAT_W-1:0] stat_in_cnt,
    output logic [STAT_W-1:0] stat_out_cnt,
    output logic              stat_hold,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W:0]     out_sum,
    output logic              busy
);

    localparam int unsigned SUM_W = OP_W + 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    op_state_t        state_q;
    op_state_t        state_d;
    logic             op_vld;
    logic             pop;
    logic             xfer;
    logic             accept;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;

    assign op_vld    = (state_q == OP_LOADED);
    assign pop       = out_valid & out_ready;
    assign xfer      = op_vld & (~fifo_full | pop);
    assign in_ready  = ~op_vld | xfer;
    assign accept    = in_valid & in_ready;
    assign out_valid = (fifo_cnt != '0);
    assign busy      = op_vld | ~fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OP_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A refill in the same cycle as the transfer keeps the register loaded.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OP_EMPTY:  if (accept)          state_d = OP_LOADED;
            OP_LOADED: if (xfer & ~accept)  state_d = OP_EMPTY;
            default:                        state_d = OP_EMPTY;
        endcase
    end

    // Operands hold their last value between acceptances.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_x_o <= '0;
            add_y_o <= '0;
        end else if (accept) begin
            add_x_o <= in_x;
            add_y_o <= in_y;
        end
    end

    rbcla_feed_fifo #(
        .W     (SUM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (xfer),
        .din   (add_s_i),
        .pop   (pop),
        .dout  (out_sum),
        .cnt   (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef RBCLA_FEED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_in_cnt  <= '0;
            stat_out_cnt <= '0;
        end else begin
            if (accept) stat_in_cnt  <= sat_inc(stat_in_cnt);
            if (pop)    stat_out_cnt <= sat_inc(stat_out_cnt);
        end
    end

    assign stat_hold = in_valid & ~in_ready;
`endif

endmodule

// File: tb/tb_rbcla_feed_stage.sv
// Self-checking bench for rbcla_feed_stage with the UBRCL_28_0_28_0 adder in the loop.
// Build with RBCLA_FEED_STATS_EN to also cover the statistics outputs.
module tb_rbcla_feed_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [28:0] in_x;
    logic [28:0] in_y;
    logic [28:0] add_x_o;
    logic [28:0] add_y_o;
    logic [29:0] add_s_i;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_sum;
    logic        busy;
`ifdef RBCLA_FEED_STATS_EN
    logic [15:0] stat_in_cnt;
    logic [15:0] stat_out_cnt;
    logic        stat_hold;
    int          m_in  = 0;
    int          m_out = 0;
    int          blocked = 0;
`endif

    rbcla_feed_stage #(.OP_W(29), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .add_x_o      (add_x_o),
        .add_y_o      (add_y_o),
        .add_s_i      (add_s_i),
`ifdef RBCLA_FEED_STATS_EN
        .stat_in_cnt  (stat_in_cnt),
        .stat_out_cnt (stat_out_cnt),
        .stat_hold    (stat_hold),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .busy         (busy)
    );

    UBRCL_28_0_28_0 u_add (
        .x (add_x_o),
        .y (add_y_o),
        .s (add_s_i)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    // Reference model: pairs held in order, split as op-register count and FIFO count.
    logic [29:0] sum_q[$];
    logic [29:0] pop_log[$];
    bit          log_en = 1'b0;
    int          op_n = 0;
    int          fifo_n = 0;
    logic [28:0] mx = '0;
    logic [28:0] my = '0;
    logic        last_acc = 1'b0;
    logic        last_pop = 1'b0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check at the falling edge, advance the model, return #1 after the rising edge.
    task automatic step();
        logic pop, xfer, exp_rdy, acc;
        @(negedge clk);
        pop     = (fifo_n > 0) && out_ready;
        xfer    = (op_n == 1) && ((fifo_n < DEPTH) || pop);
        exp_rdy = (op_n == 0) || xfer;
        acc     = in_valid && exp_rdy;
        chk("in_ready",  32'(in_ready),  32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(fifo_n > 0));
        chk("busy",      32'(busy),      32'((op_n > 0) || (fifo_n > 0)));
        chk("add_x_o",   32'(add_x_o),   32'(mx));
        chk("add_y_o",   32'(add_y_o),   32'(my));
        if (fifo_n > 0) chk("out_sum", 32'(out_sum), 32'(sum_q[0]));
`ifdef RBCLA_FEED_STATS_EN
        chk("stat_hold",    32'(stat_hold),    32'(in_valid && !exp_rdy));
        chk("stat_in_cnt",  32'(stat_in_cnt),  32'(m_in));
        chk("stat_out_cnt", 32'(stat_out_cnt), 32'(m_out));
        if (in_valid && !exp_rdy) blocked++;
`endif
        if (log_en && pop) pop_log.push_back(out_sum);
        if (rst) begin
            sum_q.delete();
            op_n = 0; fifo_n = 0; mx = '0; my = '0;
            acc = 1'b0; pop = 1'b0;
`ifdef RBCLA_FEED_STATS_EN
            m_in = 0; m_out = 0;
`endif
        end else begin
            if (pop) begin
                void'(sum_q.pop_front());
                fifo_n--;
                pop_cnt++;
            end
            if (xfer) begin
                fifo_n++;
                op_n = 0;
            end
            if (acc) begin
                sum_q.push_back(30'(in_x) + 30'(in_y));
                op_n = 1; mx = in_x; my = in_y;
                acc_cnt++;
            end
`ifdef RBCLA_FEED_STATS_EN
            if (acc && m_in < 65535) m_in++;
            if (pop && m_out < 65535) m_out++;
`endif
        end
        last_acc = acc;
        last_pop = pop;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sum_q.size() > 0 || op_n > 0) && n < max) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(sum_q.size()), 32'd0);
    endtask

    initial begin
        int k, a0, p0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_add_x",     32'(add_x_o),   32'd0);

        // Single pair with carry out of the operand width.
        out_ready = 1'b1; in_valid = 1'b1; in_x = 29'h1FFFFFFF; in_y = 29'h1;
        step();
        chk("single_acc", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        chk("single_ov_n1", 32'(out_valid), 32'd0);
        step();
        chk("single_ov_n2", 32'(out_valid), 32'd1);
        chk("single_sum",   32'(out_sum),   32'h20000000);
        step();
        chk("single_busy",  32'(busy),      32'd0);

        // Back-to-back random stream.
        p0 = pop_cnt;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_x = 29'($urandom); in_y = 29'($urandom);
            step();
            chk("stream_acc", 32'(last_acc), 32'd1);
        end
        chk("stream_pops", 32'(pop_cnt - p0), 32'd98);
        drain(10);

        // Backpressure: three held, fourth accepted on the first pop.
        out_ready = 1'b0; in_valid = 1'b1; k = 1; a0 = acc_cnt;
        for (int i = 0; i < 6; i++) begin
            in_x = 29'(k); in_y = 29'(k);
            step();
            if (last_acc) k++;
        end
        chk("bp_accepts", 32'(acc_cnt - a0), 32'd3);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        pop_log.delete(); log_en = 1'b1;
        out_ready = 1'b1;
        step();
        chk("bp_4th_acc", 32'(last_acc), 32'd1);
        chk("bp_4th_pop", 32'(last_pop), 32'd1);
        drain(10);
        log_en = 1'b0;
        chk("bp_count", 32'(pop_log.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < pop_log.size()) chk("bp_sum", 32'(pop_log[j]), 32'(2 * (j + 1)));
        end

        // Full FIFO with out_ready toggling every cycle.
        a0 = acc_cnt; p0 = pop_cnt;
        out_ready = 1'b0; in_valid = 1'b1;
        in_x = 29'($urandom); in_y = 29'($urandom);
        for (int i = 0; i < 3; i++) begin
            step();
            if (last_acc) begin in_x = 29'($urandom); in_y = 29'($urandom); end
        end
        for (int cyc = 0; cyc < 200 && ((acc_cnt - a0) < 20 || sum_q.size() > 0); cyc++) begin
            out_ready = ~out_ready;
            in_valid  = ((acc_cnt - a0) < 20);
            step();
            if (last_acc) begin in_x = 29'($urandom); in_y = 29'($urandom); end
        end
        chk("tog_accepts", 32'(acc_cnt - a0), 32'd20);
        chk("tog_pops",    32'(pop_cnt - p0), 32'd20);
        chk("tog_empty",   32'(sum_q.size()), 32'd0);

        // Reset with three pairs in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_x = 29'($urandom); in_y = 29'($urandom);
            step();
        end
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_sum",   32'(out_sum),   32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_add_x",     32'(add_x_o),   32'd0);
        chk("mid_rst_add_y",     32'(add_y_o),   32'd0);
        pop_log.delete(); log_en = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; in_x = 29'd5; in_y = 29'd7;
        step();
        drain(10);
        log_en = 1'b0;
        chk("post_rst_count", 32'(pop_log.size()), 32'd1);
        if (pop_log.size() > 0) chk("post_rst_first", 32'(pop_log[0]), 32'd12);

`ifdef RBCLA_FEED_STATS_EN
        // Blocked cycles raise stat_hold; long stream saturates the counters.
        k = blocked;
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (6) step();
        chk("hold_cycles", 32'(blocked - k), 32'd3);
        out_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            in_x = 29'($urandom); in_y = 29'($urandom);
            step();
        end
        drain(10);
        chk("stat_in_sat",  32'(stat_in_cnt),  32'h0000FFFF);
        chk("stat_out_sat", 32'(stat_out_cnt), 32'h0000FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
